// File: rtl/id_hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller:
// FSM state encoding, stall-depth codes and the hard-wired zero register.
package id_hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef logic [1:0] depth_t;

  localparam depth_t DEPTH_NONE = 2'd0;
  localparam depth_t DEPTH_ONE  = 2'd1;
  localparam depth_t DEPTH_TWO  = 2'd2;

  localparam logic [4:0] ZERO_REG = 5'd0;

  function automatic depth_t depth_max(input depth_t a, input depth_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Combinational stall-depth classifier for the instruction in ID, based on
// the producers sitting in EX and MEM and whether ID resolves a branch.
module id_hazard_detect
  import id_hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       use_rs_i,
  input  logic       use_rt_i,
  input  logic       branch_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_regwrite_i,
  input  logic       ex_memread_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_regwrite_i,
  input  logic       mem_memread_i,
  output logic [1:0] depth_o
);

  logic   ex_valid, mem_valid;
  logic   ex_rs, ex_rt, mem_rs, mem_rt;
  depth_t rs_depth, rt_depth, ex_rs_depth, mem_rs_depth;

  always_comb begin
    ex_valid  = ex_regwrite_i && (ex_rd_i != ZERO_REG);
    mem_valid = mem_regwrite_i && (mem_rd_i != ZERO_REG);
    ex_rs     = ex_valid && use_rs_i && (ex_rd_i == rs_i);
    ex_rt     = ex_valid && use_rt_i && (ex_rd_i == rt_i);
    mem_rs    = mem_valid && use_rs_i && (mem_rd_i == rs_i);
    mem_rt    = mem_valid && use_rt_i && (mem_rd_i == rt_i);

    ex_rs_depth  = DEPTH_NONE;
    mem_rs_depth = DEPTH_NONE;
    rs_depth     = DEPTH_NONE;
    rt_depth     = DEPTH_NONE;

    if (branch_i) begin
      // Rs reaches the comparator from EX/MEM and MEM/WB; Rt only from MEM/WB.
      if (ex_rs) ex_rs_depth = ex_memread_i ? DEPTH_TWO : DEPTH_ONE;
      if (mem_rs && mem_memread_i) mem_rs_depth = DEPTH_ONE;
      rs_depth = depth_max(ex_rs_depth, mem_rs_depth);
      if (ex_rt) rt_depth = DEPTH_TWO;
      else if (mem_rt) rt_depth = DEPTH_ONE;
    end else begin
      if (ex_memread_i && (ex_rs || ex_rt)) rs_depth = DEPTH_ONE;
    end

    depth_o = depth_max(rs_depth, rt_depth);
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: RUN/HOLD stall FSM, pipeline enables and a
// saturating stall counter. Define ID_HAZARD_DELAY_SLOT_EN to never flush IF.
module id_hazard_ctrl
  import id_hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_Branch,
  input  logic        ID_Taken,
  input  logic [4:0]  EX_Rd,
  input  logic [4:0]  MEM_Rd,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemRead,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic [15:0] Stall_Cycles
);

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]  depth;
  logic        stall;

  id_hazard_detect u_detect (
    .rs_i           (ID_Rs),
    .rt_i           (ID_Rt),
    .use_rs_i       (ID_UseRs),
    .use_rt_i       (ID_UseRt),
    .branch_i       (ID_Branch),
    .ex_rd_i        (EX_Rd),
    .ex_regwrite_i  (EX_RegWrite),
    .ex_memread_i   (EX_MemRead),
    .mem_rd_i       (MEM_Rd),
    .mem_regwrite_i (MEM_RegWrite),
    .mem_memread_i  (MEM_MemRead),
    .depth_o        (depth)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        stall   = (depth != DEPTH_NONE);
        state_d = (depth == DEPTH_TWO) ? HOLD : RUN;
      end
      HOLD: begin
        // Second cycle of a two-deep stall; detection is not consulted.
        stall   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (reset) stall = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;

    PC_Write     = ~stall;
    IF_ID_Write  = ~stall;
    ID_EX_Bubble = stall;
`ifdef ID_HAZARD_DELAY_SLOT_EN
    IF_ID_Flush  = 1'b0;
`else
    IF_ID_Flush  = ID_Taken && !stall && !reset;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cycles = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
  logic        ID_UseRs, ID_UseRt, ID_Branch, ID_Taken;
  logic        EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
  logic [15:0] Stall_Cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_UseRs     (ID_UseRs),
    .ID_UseRt     (ID_UseRt),
    .ID_Branch    (ID_Branch),
    .ID_Taken     (ID_Taken),
    .EX_Rd        (EX_Rd),
    .MEM_Rd       (MEM_Rd),
    .EX_RegWrite  (EX_RegWrite),
    .EX_MemRead   (EX_MemRead),
    .MEM_RegWrite (MEM_RegWrite),
    .MEM_MemRead  (MEM_MemRead),
    .PC_Write     (PC_Write),
    .IF_ID_Write  (IF_ID_Write),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EX_Bubble (ID_EX_Bubble),
    .Stall_Cycles (Stall_Cycles)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic [4:0] exrd;
    logic       exrw;
    logic       exmr;
    logic [4:0] memrd;
    logic       memrw;
    logic       memmr;
    logic [1:0] d;
  } vec_t;

  localparam int NVEC = 14;
`ifdef ID_HAZARD_DELAY_SLOT_EN
  localparam logic FLUSH_ON_TAKEN = 1'b0;
`else
  localparam logic FLUSH_ON_TAKEN = 1'b1;
`endif

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0;
    ID_Branch = 1'b0; ID_Taken = 1'b0;
    EX_Rd = 5'd0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
    MEM_Rd = 5'd0; MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    ID_Rs = v.rs; ID_Rt = v.rt; ID_UseRs = v.urs; ID_UseRt = v.urt;
    ID_Branch = v.br; ID_Taken = 1'b0;
    EX_Rd = v.exrd; EX_RegWrite = v.exrw; EX_MemRead = v.exmr;
    MEM_Rd = v.memrd; MEM_RegWrite = v.memrw; MEM_MemRead = v.memmr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    ID_Rs = 5'd8; ID_UseRs = 1'b1; ID_Branch = 1'b1; ID_Taken = 1'b1;
    EX_Rd = 5'd8; EX_RegWrite = 1'b1; EX_MemRead = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=1100",
               {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble});
    end
    step();
    checks++;
    if (Stall_Cycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", Stall_Cycles);
    end
    reset = 1'b0;
    clear_inputs();
    $display("test_reset done");
  endtask

  task automatic test_depth_table();
    vec_t vecs [NVEC];
    vecs = '{
      //  rs    rt   urs  urt  br   exrd exrw exmr memrd mrw  mmr  d
      '{5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd1}, // lw $8 -> add
      '{5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd2}, // lw $8 -> beq
      '{5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2}, // EX add, Rt
      '{5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 2'd1}, // MEM add, Rt
      '{5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd1}, // EX add, Rs
      '{5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 2'd1}, // MEM lw, Rs
      '{5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 2'd0}, // MEM add, Rs
      '{5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0}, // EX add, non-br
      '{5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd1}, // EX lw, Rt non-br
      '{5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0}, // Rt not read
      '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 2'd0}, // $0 producers
      '{5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0}, // no RegWrite
      '{5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 2'd2}, // max(Rs1,Rt2)
      '{5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 2'd0}  // MEM lw, non-br
    };
    for (int i = 0; i < NVEC; i++) begin
      logic first_stall, second_stall;
      do_reset();
      apply_vec(vecs[i]);
      first_stall  = (vecs[i].d != 2'd0);
      second_stall = (vecs[i].d == 2'd2);
      @(negedge clk);
      checks++;
      if ({PC_Write, IF_ID_Write, ID_EX_Bubble} !== {!first_stall, !first_stall, first_stall}) begin
        failures++;
        $display("FAIL vec%0d_cycle1 pc/ifid/bubble got=%b%b%b want=%b%b%b", i,
                 PC_Write, IF_ID_Write, ID_EX_Bubble, !first_stall, !first_stall, first_stall);
      end
      step();
      // Producer has moved on; any stall now comes only from the held state.
      clear_inputs();
      @(negedge clk);
      checks++;
      if ({PC_Write, ID_EX_Bubble} !== {!second_stall, second_stall}) begin
        failures++;
        $display("FAIL vec%0d_cycle2 pc/bubble got=%b%b want=%b%b", i,
                 PC_Write, ID_EX_Bubble, !second_stall, second_stall);
      end
      step();
      checks++;
      if (Stall_Cycles !== {14'd0, vecs[i].d}) begin
        failures++;
        $display("FAIL vec%0d_count got=%0d want=%0d", i, Stall_Cycles, vecs[i].d);
      end
      $display("vec%0d depth=%0d stall_cycles=%0d", i, vecs[i].d, Stall_Cycles);
    end
  endtask

  task automatic test_flush_r0();
    do_reset();
    ID_Branch = 1'b1; ID_UseRs = 1'b1; ID_UseRt = 1'b1; ID_Taken = 1'b1;
    EX_Rd = 5'd0; EX_RegWrite = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Flush} !== {1'b1, FLUSH_ON_TAKEN}) begin
      failures++;
      $display("FAIL flush_taken pc/flush got=%b%b want=1%b", PC_Write, IF_ID_Flush, FLUSH_ON_TAKEN);
    end
    ID_Taken = 1'b0;
    #1;
    checks++;
    if (IF_ID_Flush !== 1'b0) begin
      failures++;
      $display("FAIL flush_not_taken got=%b want=0", IF_ID_Flush);
    end
    step();
    $display("test_flush_r0 done");
  endtask

  task automatic test_flush_during_stall();
    do_reset();
    ID_Branch = 1'b1; ID_UseRs = 1'b1; ID_Rs = 5'd8; ID_Taken = 1'b1;
    EX_Rd = 5'd8; EX_RegWrite = 1'b1; EX_MemRead = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Flush} !== 2'b00) begin
      failures++;
      $display("FAIL flush_stall_run pc/flush got=%b%b want=00", PC_Write, IF_ID_Flush);
    end
    step();
    clear_inputs();
    ID_Taken = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Flush} !== 2'b00) begin
      failures++;
      $display("FAIL flush_stall_hold pc/flush got=%b%b want=00", PC_Write, IF_ID_Flush);
    end
    step();
    $display("test_flush_during_stall done");
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    ID_Branch = 1'b1; ID_UseRt = 1'b1; ID_Rt = 5'd9;
    EX_Rd = 5'd9; EX_RegWrite = 1'b1;
    step();
    reset = 1'b1;
    ID_Taken = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_in_hold_outputs got=%b want=1100",
               {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble});
    end
    step();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({PC_Write, ID_EX_Bubble} !== 2'b10) begin
      failures++;
      $display("FAIL reset_in_hold_run pc/bubble got=%b%b want=10", PC_Write, ID_EX_Bubble);
    end
    checks++;
    if (Stall_Cycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_in_hold_count got=%0d want=0", Stall_Cycles);
    end
    step();
    $display("test_reset_in_hold done");
  endtask

  task automatic test_saturation();
    do_reset();
    ID_UseRs = 1'b1; ID_Rs = 5'd8;
    EX_Rd = 5'd8; EX_RegWrite = 1'b1; EX_MemRead = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    checks++;
    if (Stall_Cycles !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_pre got=%h want=fffe", Stall_Cycles);
    end
    step();
    checks++;
    if (Stall_Cycles !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_reach got=%h want=ffff", Stall_Cycles);
    end
    step();
    step();
    checks++;
    if (Stall_Cycles !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold got=%h want=ffff", Stall_Cycles);
    end
    clear_inputs();
    $display("test_saturation stall_cycles=%h", Stall_Cycles);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_depth_table();
    test_flush_r0();
    test_flush_during_stall();
    test_reset_in_hold();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ID_Rs, ID_Rt  in  5 each  source registers of instruction in ID.
REQ-004 ID_UseRs, ID_UseRt  in  1 each  instruction reads Rs / Rt.
REQ-005 ID_Branch  in  1  branch/jr resolved in ID (operands needed in ID).
REQ-006 ID_Taken  in  1  branch taken or jump in ID; valid only when not stalling.
REQ-007 EX_Rd, MEM_Rd  in  5 each; EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead  in  1 each.
REQ-008 PC_Write, IF_ID_Write  out  1  pipeline advance enables.
REQ-009 IF_ID_Flush  out  1  squash instruction in IF; ID_EX_Bubble  out  1  insert NOP into ID/EX.
REQ-010 Stall_Cycles  out  16  saturating count of stall cycles.

Function
REQ-011 Producer match: RegWrite=1, Rd!=0, Rd equals a register read (UseRs/UseRt=1).
REQ-012 Non-branch: EX load match on Rs or Rt -> depth 1; otherwise 0.
REQ-013 Branch, Rs path (forwardable from EX/MEM and MEM/WB): EX ALU match -> 1; EX load match -> 2; MEM load match -> 1; MEM ALU match -> 0.
REQ-014 Branch, Rt path (forwardable from MEM/WB only): EX match (any) -> 2; MEM match (any) -> 1.
REQ-015 Required depth SHALL be the maximum over Rs and Rt paths.
REQ-016 States: RUN, HOLD. In RUN, depth>=1 SHALL assert stall combinationally that cycle; depth 2 SHALL move to HOLD, else remain RUN.
REQ-017 HOLD SHALL force stall for exactly one cycle, ignore detection inputs, then return to RUN (which re-evaluates).
REQ-018 Stall: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0; no stall: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0.
REQ-019 IF_ID_Flush SHALL equal ID_Taken when not stalling, 0 when stalling.
REQ-020 Stall_Cycles SHALL increment by 1 each stalled cycle, saturate at 16'hFFFF.
REQ-021 Total stall latency SHALL never exceed 2 consecutive cycles per ID instruction.

Reset
REQ-022 reset=1 at a clock edge SHALL set state RUN and Stall_Cycles=0, including mid-HOLD.
REQ-023 While reset=1 outputs SHALL be PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, regardless of other inputs.

Configuration
REQ-024 Macro ID_HAZARD_DELAY_SLOT_EN defined: IF_ID_Flush SHALL be tied 0 (delay slot executes); undefined: REQ-019 applies.

Structure
REQ-025 Shared package SHALL hold state encoding (RUN, HOLD), depth codes (0,1,2) and the zero-register constant.
REQ-026 Depth classification (REQ-011..015) SHALL be a combinational sub-module id_hazard_detect; FSM, output logic and counter in id_hazard_ctrl.

Verification
REQ-027 EX lw $8, ID add using $8 (non-branch) -> one cycle PC_Write=0, ID_EX_Bubble=1, Stall_Cycles 0->1.
REQ-028 EX lw $8, ID beq $8,$0 -> two consecutive stall cycles (RUN->HOLD->RUN), Stall_Cycles=2.
REQ-029 EX add $9 (RegWrite), ID beq $0,$9 (Rt) -> two stall cycles; MEM add $9 instead -> one; EX add $9 as Rs -> one.
REQ-030 EX_Rd=0 with RegWrite=1, ID branch reading $0 -> no stall; ID_Taken=1 -> IF_ID_Flush=1 (0 with ID_HAZARD_DELAY_SLOT_EN).
REQ-031 reset=1 during HOLD -> next cycle state RUN, PC_Write=1, Stall_Cycles=0; ID_Taken=1 during stall -> IF_ID_Flush=0.
REQ-032 Force 65 537 stall cycles -> Stall_Cycles holds 16'hFFFF.
